// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the pipeline hazard controller.
//   hazard_state_e : controller state (run, memory wait, branch flush)
//   REG_IDX_W      : register index width
//   WDOG_W         : memory-wait watchdog width
//   PERF_CNT_W     : performance counter width (HAZARD_PERF_CNT_EN builds only)
package hazard_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned WDOG_W     = 8;
  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: stall-cycle and honoured-branch counters for the hazard controller.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : PC held this cycle
//   flush_taken   : taken branch honoured this cycle
//   stall_cycles  : wrapping count of stalled cycles
//   flush_count   : wrapping count of honoured branches
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush_taken,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count
);

  logic [PERF_CNT_W-1:0] stall_q, stall_d;
  logic [PERF_CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall)       stall_d = stall_q + 1'b1;
    if (flush_taken) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised pipeline hazard sequencer (memory freeze > branch flush > load-use).
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cycles / flush_count outputs.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   id_ex_memread, id_ex_rd          : load in EX and its destination
//   if_id_rs1, if_id_rs2             : sources of the instruction in ID
//   branch_taken                     : EX resolves a taken branch/jump
//   dmem_req, dmem_ready             : MEM access pending / completing
//   pc_write .. ex_mem_write         : stage register write enables
//   control_mux_sel                  : 1 = decoded control, 0 = bubble into ID/EX
//   if_id_flush, id_ex_flush         : stage register clears
//   mem_err                          : one-cycle pulse on memory watchdog timeout
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_ex_memread,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_write,
  output logic                 ex_mem_write,
  output logic                 control_mux_sel,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count
`endif
);

  hazard_state_e     state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;

  logic pc_w, if_id_w, id_ex_w, ex_mem_w, ctrl_sel, if_id_fl, id_ex_fl, err;
  logic load_use, freeze_enter, freeze_hold;

  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign freeze_enter = (state_q != StMemWait) && dmem_req && !dmem_ready;
  assign freeze_hold  = (state_q == StMemWait) && !dmem_ready &&
                        (wdog_q != WDOG_W'(MEM_TIMEOUT));

  always_comb begin
    pc_w        = 1'b1;
    if_id_w     = 1'b1;
    id_ex_w     = 1'b1;
    ex_mem_w    = 1'b1;
    ctrl_sel    = 1'b1;
    if_id_fl    = 1'b0;
    id_ex_fl    = 1'b0;
    err         = 1'b0;
    state_d     = state_q;
    wdog_d      = wdog_q;
    flush_cnt_d = flush_cnt_q;

    if (freeze_enter || freeze_hold) begin
      pc_w        = 1'b0;
      if_id_w     = 1'b0;
      id_ex_w     = 1'b0;
      ex_mem_w    = 1'b0;
      state_d     = StMemWait;
      wdog_d      = freeze_enter ? WDOG_W'(1) : wdog_q + 1'b1;
      flush_cnt_d = '0;
    end else begin
      // Release cycle out of MEM_WAIT behaves like RUN; no ready here means timeout.
      err    = (state_q == StMemWait) && !dmem_ready;
      wdog_d = '0;
      if (branch_taken) begin
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
        if (BR_PENALTY > 1) begin
          state_d     = StFlush;
          flush_cnt_d = 2'(BR_PENALTY - 1);
        end else begin
          state_d     = StRun;
          flush_cnt_d = '0;
        end
      end else if (state_q == StFlush) begin
        if_id_fl    = 1'b1;
        flush_cnt_d = flush_cnt_q - 2'd1;
        state_d     = (flush_cnt_q <= 2'd1) ? StRun : StFlush;
      end else begin
        state_d = StRun;
        if (load_use) begin
          pc_w     = 1'b0;
          if_id_w  = 1'b0;
          ctrl_sel = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wdog_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are forced low asynchronously while reset is held.
  assign pc_write        = pc_w     & rst_n;
  assign if_id_write     = if_id_w  & rst_n;
  assign id_ex_write     = id_ex_w  & rst_n;
  assign ex_mem_write    = ex_mem_w & rst_n;
  assign control_mux_sel = ctrl_sel & rst_n;
  assign if_id_flush     = if_id_fl & rst_n;
  assign id_ex_flush     = id_ex_fl & rst_n;
  assign mem_err         = err      & rst_n;

`ifdef HAZARD_PERF_CNT_EN
  // id_ex_flush is asserted exactly in cycles where a taken branch is honoured.
  hazard_perf_cnt u_perf_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (!pc_w),
    .flush_taken  (id_ex_fl),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule
